hpu_phase_ctrl: RTL and testbench

- Sequences one HPU job through its receive modes: config receive (com), data receive/execute (run), pipeline drain, result send (gen).
- Drives the mutually exclusive com/run/gen mode lines that gate the receive-enable logic.
- Counts accepted beats per phase from the get_c/get_v strobes and sent beats from the put handshake.
- Sits between the host-side start/length interface and the receive/execute/send datapath.

---
 rtl/hpu_phase_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_hpu_phase_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpu_phase_ctrl.sv
// hpu_phase_ctrl: sequences one HPU job through config receive (COM),
// data receive/execute (RUN), pipeline drain (DRAIN) and result send (GEN).
// Mode lines, busy and done are decoded straight from the state register,
// so an asynchronous reset drops them immediately.
//
// Optional feature: define HPU_PHASE_CTRL_TIMEOUT_EN to build a stall
// watchdog that sets the sticky err flag and returns to IDLE when COM, RUN
// or GEN sees no counted beat for TIMEOUT_CYCLES consecutive cycles.
//
// Handshake: get_c / get_v are already-accepted beat strobes (valid & ready
// & mode) and are counted only in their own phase; a result beat counts when
// put_valid and put_ready are both high in GEN.
module hpu_phase_ctrl #(
  parameter int CNT_W          = 16,
  parameter int DRAIN_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] com_beats,
  input  logic [CNT_W-1:0] run_beats,
  input  logic [CNT_W-1:0] gen_beats,
  input  logic             get_c,
  input  logic             get_v,
  input  logic             put_valid,
  input  logic             put_ready,
  output logic             com,
  output logic             run,
  output logic             gen,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COM   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_GEN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [7:0]       DRAIN_INIT = 8'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] com_len_q, com_len_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] gen_len_q, gen_len_d;
  logic [7:0]       drain_q, drain_d;
  logic             beat;

`ifdef HPU_PHASE_CTRL_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d;
`endif

  // A beat counts only in the phase that owns its strobe.
  assign beat = ((state_q == S_COM) && get_c) ||
                ((state_q == S_RUN) && get_v) ||
                ((state_q == S_GEN) && put_valid && put_ready);

  // Next-state, beat counting, length latching and watchdog.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    com_len_d = com_len_q;
    run_len_d = run_len_q;
    gen_len_d = gen_len_q;
    drain_d   = drain_q;
`ifdef HPU_PHASE_CTRL_TIMEOUT_EN
    err_d     = err_q;
    stall_d   = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          com_len_d = com_beats;
          run_len_d = run_beats;
          gen_len_d = gen_beats;
`ifdef HPU_PHASE_CTRL_TIMEOUT_EN
          err_d     = 1'b0;
`endif
          if (com_beats != '0) begin
            state_d = S_COM;
            cnt_d   = com_beats;
          end else if (run_beats != '0) begin
            state_d = S_RUN;
            cnt_d   = run_beats;
          end else if (gen_beats != '0) begin
            state_d = S_GEN;
            cnt_d   = gen_beats;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_COM: begin
        if (beat) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            if (run_len_q != '0) begin
              state_d = S_RUN;
              cnt_d   = run_len_q;
            end else if (gen_len_q != '0) begin
              state_d = S_GEN;
              cnt_d   = gen_len_q;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_RUN: begin
        if (beat) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - 8'd1;
        if (drain_q == 8'd1) begin
          if (gen_len_q != '0) begin
            state_d = S_GEN;
            cnt_d   = gen_len_q;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GEN: begin
        if (beat) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef HPU_PHASE_CTRL_TIMEOUT_EN
    // Watchdog counts only stalled cycles in the beat-driven phases; any
    // beat or state change leaves stall_d at its cleared default.
    if (((state_q == S_COM) || (state_q == S_RUN) || (state_q == S_GEN)) &&
        !beat) begin
      if (stall_q == STALL_LAST) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        stall_d = stall_q + STALL_W'(1);
      end
    end
`endif

    // Abort wins over start, phase completion and timeout.
    if (abort) begin
      state_d = S_IDLE;
`ifdef HPU_PHASE_CTRL_TIMEOUT_EN
      err_d   = err_q;
      stall_d = '0;
`endif
    end
  end

  // State, counter and latched lengths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      com_len_q <= '0;
      run_len_q <= '0;
      gen_len_q <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      com_len_q <= com_len_d;
      run_len_q <= run_len_d;
      gen_len_q <= gen_len_d;
      drain_q   <= drain_d;
    end
  end

`ifdef HPU_PHASE_CTRL_TIMEOUT_EN
  // Stall counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign com   = (state_q == S_COM);
  assign run   = (state_q == S_RUN);
  assign gen   = (state_q == S_GEN);
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign state = state_q;

endmodule

// File: tb/tb_hpu_phase_ctrl.sv
// Bench for hpu_phase_ctrl: directed job table, hand-written corner
// sequences (abort, async reset, timeout) and a randomized run checked
// against a phase-segment queue model.
module tb_hpu_phase_ctrl;

  localparam int CNT_W = 16;
  localparam int DRAIN = 4;
  localparam int TMO   = 16;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             start, abort;
  logic [CNT_W-1:0] com_beats, run_beats, gen_beats;
  logic             get_c, get_v, put_valid, put_ready;
  logic             com, run, gen, busy, done, err;
  logic [2:0]       state;

  always #5 clk = ~clk;

  hpu_phase_ctrl #(
    .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .com_beats(com_beats), .run_beats(run_beats), .gen_beats(gen_beats),
    .get_c(get_c), .get_v(get_v), .put_valid(put_valid), .put_ready(put_ready),
    .com(com), .run(run), .gen(gen), .busy(busy), .done(done), .err(err),
    .state(state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    start = 0; abort = 0; get_c = 0; get_v = 0; put_valid = 0; put_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); @(negedge clk); rst = 0;
  endtask

  // ---------------- driver: one job, cycle k=0 is the start cycle ----------------
  task automatic run_job(input int c, input int r, input int g, input int gap, input bit tog,
                         output int total, output int cc, output int rc, output int gc,
                         output int dc, output int first);
    total = -1; cc = 0; rc = 0; gc = 0; dc = 0; first = -1;
    com_beats = CNT_W'(c); run_beats = CNT_W'(r); gen_beats = CNT_W'(g);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (k == 1) first = int'(state);
        cc += int'(com); rc += int'(run); gc += int'(gen);
        if (busy && !com && !run && !gen && !done) dc++;
        if (done) begin
          total = k + 1;
          break;
        end
      end
      start     = (k == 0);
      get_c     = ((k % (gap + 1)) == 0);
      get_v     = ((k % (gap + 1)) == 0);
      put_valid = 1'b1;
      put_ready = tog ? ((k % 2) == 1) : 1'b1;
    end
    clear_inputs();
  endtask

  // ---------------- directed job table ----------------
  typedef struct {
    int c, r, g, gap;
    bit tog;
    int total, cc, rc, gc, dc, first;
  } vec_t;

  vec_t vecs[5];

  // ---------------- reference model for random phase ----------------
  typedef struct packed {
    logic [2:0]  ph;
    logic [15:0] rem;
  } seg_t;

  seg_t exp_q[$];
  bit   model_err;
`ifdef HPU_PHASE_CTRL_TIMEOUT_EN
  int   stall;
`endif

  task automatic model_start(input int c, input int r, input int g);
    if (c > 0) exp_q.push_back('{3'd1, 16'(c)});
    if (r > 0) begin
      exp_q.push_back('{3'd2, 16'(r)});
      exp_q.push_back('{3'd3, 16'(DRAIN)});
    end
    if (g > 0) exp_q.push_back('{3'd4, 16'(g)});
    exp_q.push_back('{3'd5, 16'd1});
  endtask

  initial begin
    int total, cc, rc, gc, dc, first;
    logic [8:0] exp_v, act_v;
    seg_t s;
    bit ev;
    int rc_cnt, rr_cnt, rg_cnt;

    rst = 1; com_beats = 0; run_beats = 0; gen_beats = 0;
    clear_inputs();

    // Reset state
    @(negedge clk);
    check("reset_state", 32'(state), 0);
    check("reset_outs", 32'({com, run, gen, busy, done, err}), 0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    check("post_reset_state", 32'(state), 0);

    // Expected counts: total = 1 + com + run + (run ? DRAIN : 0) + gen cycles + 1
    vecs[0] = '{2, 3, 2, 0, 1'b0, 13, 2, 3, 2, 4, 1};
    vecs[1] = '{0, 0, 1, 0, 1'b0,  3, 0, 0, 1, 0, 4};
    vecs[2] = '{0, 0, 0, 0, 1'b0,  2, 0, 0, 0, 0, 5};
    // get_v every 4th cycle (k=4,8,12,16), put_ready high on odd k
    vecs[3] = '{0, 4, 3, 3, 1'b1, 27, 0, 16, 5, 4, 2};
    vecs[4] = '{3, 0, 0, 0, 1'b0,  5, 3, 0, 0, 0, 1};

    foreach (vecs[i]) begin
      run_job(vecs[i].c, vecs[i].r, vecs[i].g, vecs[i].gap, vecs[i].tog,
              total, cc, rc, gc, dc, first);
      check($sformatf("vec%0d_total", i), 32'(total), 32'(vecs[i].total));
      check($sformatf("vec%0d_first", i), 32'(first), 32'(vecs[i].first));
      check($sformatf("vec%0d_com", i), 32'(cc), 32'(vecs[i].cc));
      check($sformatf("vec%0d_run", i), 32'(rc), 32'(vecs[i].rc));
      check($sformatf("vec%0d_gen", i), 32'(gc), 32'(vecs[i].gc));
      check($sformatf("vec%0d_drain", i), 32'(dc), 32'(vecs[i].dc));
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", i), 32'({state, busy, done}), 0);
    end

    // Abort in RUN after 1 of 5 beats
    com_beats = 0; run_beats = 5; gen_beats = 0;
    start = 1;
    @(negedge clk); start = 0;
    check("abort_in_run", 32'(state), 2);
    get_v = 1;
    @(negedge clk); get_v = 0; abort = 1;
    check("abort_still_run", 32'(run), 1);
    @(negedge clk); abort = 0;
    check("abort_idle", 32'({state, busy, done}), 0);
    @(negedge clk);
    check("abort_no_done", 32'({state, done}), 0);
    run_job(1, 1, 1, 0, 1'b0, total, cc, rc, gc, dc, first);
    check("after_abort_total", 32'(total), 9);
    check("after_abort_drain", 32'(dc), 4);
    @(negedge clk);

    // Async reset mid-GEN
    com_beats = 0; run_beats = 0; gen_beats = 3;
    start = 1; put_valid = 1; put_ready = 0;
    @(negedge clk); start = 0;
    check("rst_gen_before", 32'({gen, busy}), 3);
    #2 rst = 1;
    #1;
    check("rst_gen_async", 32'({gen, busy, state}), 0);
    @(negedge clk); rst = 0; clear_inputs();
    @(negedge clk);
    check("rst_gen_after", 32'({state, busy}), 0);

    // Stall in COM
    com_beats = 2; run_beats = 0; gen_beats = 0;
    start = 1;
    @(negedge clk); start = 0;
    rc_cnt = 0; rr_cnt = 0;
`ifdef HPU_PHASE_CTRL_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      if (k > 1) @(negedge clk);
      rc_cnt += int'(com); rr_cnt += int'(done);
    end
    @(negedge clk);
    check("tmo_com_cycles", 32'(rc_cnt), 32'(TMO));
    check("tmo_no_done", 32'(rr_cnt), 0);
    check("tmo_state_idle", 32'(state), 0);
    check("tmo_err", 32'(err), 1);
`else
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      rc_cnt += int'(com); rr_cnt += int'(err);
    end
    check("stall_com_cycles", 32'(rc_cnt), 40);
    check("stall_err_low", 32'(rr_cnt), 0);
    check("stall_state_com", 32'(state), 1);
    abort = 1;
    @(negedge clk); abort = 0;
    check("stall_abort_idle", 32'(state), 0);
`endif

    // Randomized run against the segment-queue model
    do_reset();
    exp_q.delete();
    model_err = 0;
`ifdef HPU_PHASE_CTRL_TIMEOUT_EN
    stall = 0;
`endif
    rg_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (exp_q.size() != 0) s = exp_q[0]; else s = '{3'd0, 16'd0};
      exp_v = {s.ph, s.ph == 3'd1, s.ph == 3'd2, s.ph == 3'd4,
               exp_q.size() != 0, s.ph == 3'd5, model_err};
      act_v = {state, com, run, gen, busy, done, err};
      if (act_v !== exp_v) rg_cnt++;
      check($sformatf("rand_cyc%0d", cyc), 32'(act_v), 32'(exp_v));

      start     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 63) == 0);
      com_beats = CNT_W'($urandom_range(0, 4));
      run_beats = CNT_W'($urandom_range(0, 4));
      gen_beats = CNT_W'($urandom_range(0, 4));
      get_c     = $urandom_range(0, 1) == 1;
      get_v     = $urandom_range(0, 1) == 1;
      put_valid = $urandom_range(0, 1) == 1;
      put_ready = $urandom_range(0, 1) == 1;

      if (abort) begin
        exp_q.delete();
`ifdef HPU_PHASE_CTRL_TIMEOUT_EN
        stall = 0;
`endif
      end else if (exp_q.size() == 0) begin
        if (start) begin
          model_start(int'(com_beats), int'(run_beats), int'(gen_beats));
          model_err = 0;
`ifdef HPU_PHASE_CTRL_TIMEOUT_EN
          stall = 0;
`endif
        end
      end else begin
        ev = (s.ph == 3'd1 && get_c) || (s.ph == 3'd2 && get_v) ||
             (s.ph == 3'd4 && put_valid && put_ready) ||
             s.ph == 3'd3 || s.ph == 3'd5;
        if (ev) begin
          s.rem = s.rem - 16'd1;
          if (s.rem == 0) void'(exp_q.pop_front());
          else exp_q[0] = s;
`ifdef HPU_PHASE_CTRL_TIMEOUT_EN
          stall = 0;
        end else begin
          stall++;
          if (stall == TMO) begin
            exp_q.delete();
            model_err = 1;
            stall = 0;
          end
`endif
        end
      end
    end
    clear_inputs();
    check("rand_mismatch_cycles", 32'(rg_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
